// File: rtl/multicycle_exec_unit.sv
// multicycle_exec_unit: instruction field decoder, 32-bit ALU with branch
// decision, and a word-addressed data memory (synchronous write,
// combinational read, asynchronously cleared by reset).
module multicycle_exec_unit #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic [2:0]  opcode,
    output logic [4:0]  reg_addr_0,
    output logic [4:0]  reg_addr_1,
    output logic [4:0]  reg_addr_2,
    output logic [15:0] addr,
    input  logic [31:0] ip_0,
    input  logic [31:0] ip_1,
    output logic [31:0] op_0,
    output logic        change_pc,
    input  logic [15:0] data_address,
    input  logic        write_en,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    // Index width into the word array; upper data_address bits are dropped so
    // addresses alias modulo MEM_DEPTH.
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_BEQ   = 3'b111;

    logic signed [31:0] opa_s;
    logic signed [31:0] opb_s;
    logic signed [31:0] sum_s;
    logic signed [31:0] diff_s;
    logic [IDX_W-1:0]   mem_idx;
    logic [31:0]        mem_q [MEM_DEPTH];

    // Decoder: pure field slicing; addr deliberately overlaps reg_addr_2.
    assign opcode     = inst[31:29];
    assign reg_addr_0 = inst[28:24];
    assign reg_addr_1 = inst[23:19];
    assign reg_addr_2 = inst[18:14];
    assign addr       = inst[15:0];

    // Two's-complement add/subtract; the carry out is simply not kept.
    assign opa_s  = signed'(ip_0);
    assign opb_s  = signed'(ip_1);
    assign sum_s  = opa_s + opb_s;
    assign diff_s = opa_s - opb_s;

    // ALU result and branch decision, selected by the decoded opcode.
    always_comb begin
        op_0      = '0;
        change_pc = 1'b0;
        case (opcode)
            OP_LOAD:  op_0 = '0;
            OP_STORE: op_0 = '0;
            OP_ADD:   op_0 = unsigned'(sum_s);
            OP_SUB:   op_0 = unsigned'(diff_s);
            OP_AND:   op_0 = ip_0 & ip_1;
            OP_OR:    op_0 = ip_0 | ip_1;
            OP_XOR:   op_0 = ip_0 ^ ip_1;
            OP_BEQ: begin
                op_0      = unsigned'(diff_s);
                change_pc = (ip_0 == ip_1);
            end
            default: begin
                op_0      = '0;
                change_pc = 1'b0;
            end
        endcase
    end

    assign mem_idx = data_address[IDX_W-1:0];

    // Data memory: reset clears every word at once and blocks writes while low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[mem_idx] <= write_data;
        end
    end

    // Combinational read: a same-cycle write shows up only after the edge.
    assign read_data = mem_q[mem_idx];

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// Scoreboard bench for multicycle_exec_unit: stimulus queues expected values,
// a negedge monitor pops and compares them against the live outputs.
module tb_multicycle_exec_unit;

    localparam int MEM_DEPTH = 256;

    localparam int K_OPC  = 0;
    localparam int K_RA0  = 1;
    localparam int K_RA1  = 2;
    localparam int K_RA2  = 3;
    localparam int K_ADDR = 4;
    localparam int K_OP0  = 5;
    localparam int K_CPC  = 6;
    localparam int K_RD   = 7;

    typedef struct {
        string       nm;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [2:0]  opcode;
    logic [4:0]  reg_addr_0;
    logic [4:0]  reg_addr_1;
    logic [4:0]  reg_addr_2;
    logic [15:0] addr;
    logic [31:0] ip_0;
    logic [31:0] ip_1;
    logic [31:0] op_0;
    logic        change_pc;
    logic [15:0] data_address;
    logic        write_en;
    logic [31:0] write_data;
    logic [31:0] read_data;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    multicycle_exec_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .opcode       (opcode),
        .reg_addr_0   (reg_addr_0),
        .reg_addr_1   (reg_addr_1),
        .reg_addr_2   (reg_addr_2),
        .addr         (addr),
        .ip_0         (ip_0),
        .ip_1         (ip_1),
        .op_0         (op_0),
        .change_pc    (change_pc),
        .data_address (data_address),
        .write_en     (write_en),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string nm, input int kind, input logic [31:0] v);
        exp_t e;
        e.nm   = nm;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge; monitor runs at the negedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string nm, input logic [2:0] opc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic cpc);
        inst = {opc, 29'd0};
        ip_0 = a;
        ip_1 = b;
        push({nm, "_op0"}, K_OP0, res);
        push({nm, "_cpc"}, K_CPC, {31'd0, cpc});
        step();
    endtask

    // Monitor: compare every queued expectation against the presented outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_OPC:   act = {29'd0, opcode};
                K_RA0:   act = {27'd0, reg_addr_0};
                K_RA1:   act = {27'd0, reg_addr_1};
                K_RA2:   act = {27'd0, reg_addr_2};
                K_ADDR:  act = {16'd0, addr};
                K_OP0:   act = op_0;
                K_CPC:   act = {31'd0, change_pc};
                default: act = read_data;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
            end
        end
    end

    initial begin
        rst_n        = 1'b1;
        inst         = '0;
        ip_0         = '0;
        ip_1         = '0;
        data_address = '0;
        write_en     = 1'b0;
        write_data   = '0;
        #2 rst_n = 1'b0;
        step();
        push("reset_rd0", K_RD, 32'h0);
        step();
        data_address = 16'd200;
        push("reset_rd200", K_RD, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        inst = 32'h4A2C_1234;
        push("dec_opcode", K_OPC, 32'h2);
        push("dec_ra0",    K_RA0, 32'h0A);
        push("dec_ra1",    K_RA1, 32'h05);
        push("dec_ra2",    K_RA2, 32'h10);
        push("dec_addr",   K_ADDR, 32'h1234);
        step();

        alu("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        alu("sub_wrap", 3'b011, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
        alu("and",      3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
        alu("or",       3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
        alu("xor",      3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
        alu("beq_eq",   3'b111, 32'd7, 32'd7, 32'h0, 1'b1);
        alu("beq_ne",   3'b111, 32'd7, 32'd8, 32'hFFFF_FFFF, 1'b0);
        alu("add_eq",   3'b010, 32'd7, 32'd7, 32'd14, 1'b0);
        alu("load",     3'b000, 32'd9, 32'd3, 32'h0, 1'b0);
        alu("store",    3'b001, 32'd9, 32'd9, 32'h0, 1'b0);

        // Write DEAD_BEEF at 5: old value visible until the edge.
        data_address = 16'd5;
        write_data   = 32'hDEAD_BEEF;
        write_en     = 1'b1;
        push("rdw_old", K_RD, 32'h0);
        step();
        write_en = 1'b0;
        write_data = 32'h1111_2222;
        push("wr_rd5", K_RD, 32'hDEAD_BEEF);
        step();
        data_address = 16'(5 + MEM_DEPTH);
        push("alias_rd", K_RD, 32'hDEAD_BEEF);
        step();
        data_address = 16'd5;
        push("noen_rd5", K_RD, 32'hDEAD_BEEF);
        step();

        // Back-to-back writes to 9.
        data_address = 16'd9;
        write_en     = 1'b1;
        write_data   = 32'd1;
        step();
        write_data = 32'd2;
        step();
        write_en = 1'b0;
        push("b2b_rd9", K_RD, 32'd2);
        step();

        // Fill 0..3 then reset between edges.
        write_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_address = 16'(i);
            write_data   = 32'hA000_0000 + 32'(i);
            step();
        end
        write_en     = 1'b0;
        data_address = 16'd3;
        push("fill_rd3", K_RD, 32'hA000_0003);
        step();
        rst_n = 1'b0;
        push("rst_rd3", K_RD, 32'h0);
        write_en   = 1'b1;
        write_data = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            step();
            data_address = 16'(i);
            push($sformatf("rst_rd%0d", i), K_RD, 32'h0);
        end
        step();
        rst_n    = 1'b1;
        write_en = 1'b0;
        data_address = 16'd2;
        push("post_rst_rd2", K_RD, 32'h0);
        step();
        data_address = 16'd5;
        push("post_rst_rd5", K_RD, 32'h0);
        step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
